// File: rtl/bus_select_encoder_if.sv
// Bus-select encoder signal bundle: control-unit strobes in, encoded select and
// conflict status out. master = control unit side, slave = encoder side.
interface bus_select_encoder_if;
  logic [31:0] src_out;
  logic        freeze;
  logic        err_clr;
  logic [4:0]  Select;
  logic        sel_valid;
  logic        conflict;
  logic        conflict_sticky;
  logic [4:0]  conflict_src;
  logic [7:0]  conflict_cnt;

  modport master (
    output src_out, freeze, err_clr,
    input  Select, sel_valid, conflict, conflict_sticky, conflict_src, conflict_cnt
  );

  modport slave (
    input  src_out, freeze, err_clr,
    output Select, sel_valid, conflict, conflict_sticky, conflict_src, conflict_cnt
  );
endinterface

// File: rtl/bus_select_encoder.sv
// Registered 32-to-5 one-hot encoder for the bus mux select, with multi-driver
// detection. Define BUS_SELECT_CONFLICT_CNT_EN to build the saturating conflict counter.
module bus_select_encoder #(
  parameter bit         HOLD_LAST = 1'b1,
  parameter logic [4:0] IDLE_SEL  = 5'd0
) (
  input  logic                 clock,
  input  logic                 clear_n,
  bus_select_encoder_if.slave  bus
);

  logic [4:0] loIdx;
  logic [4:0] hiIdx;
  logic       anySrc;
  logic       multiSrc;

  logic [4:0] selQ;
  logic       validQ;
  logic       conflictQ;
  logic       stickyQ;
  logic [4:0] conflictSrcQ;

  // Lowest set bit wins the bus; highest set bit is reported as the offender.
  always_comb begin
    loIdx = '0;
    hiIdx = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (bus.src_out[31 - i]) loIdx = 5'(31 - i);
      if (bus.src_out[i])      hiIdx = 5'(i);
    end
  end

  always_comb begin
    anySrc   = |bus.src_out;
    multiSrc = |(bus.src_out & (bus.src_out - 32'd1));
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      selQ         <= IDLE_SEL;
      validQ       <= 1'b0;
      conflictQ    <= 1'b0;
      stickyQ      <= 1'b0;
      conflictSrcQ <= '0;
    end else if (!bus.freeze) begin
      validQ    <= anySrc;
      conflictQ <= multiSrc;
      if (anySrc) begin
        selQ <= loIdx;
      end else if (!HOLD_LAST) begin
        selQ <= IDLE_SEL;
      end
      if (multiSrc) begin
        stickyQ      <= 1'b1;
        conflictSrcQ <= hiIdx;
      end else if (bus.err_clr) begin
        stickyQ <= 1'b0;
      end
    end
  end

`ifdef BUS_SELECT_CONFLICT_CNT_EN
  logic [7:0] cntQ;

  // A conflict in the same cycle as err_clr restarts the count at one.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cntQ <= '0;
    end else if (!bus.freeze) begin
      if (multiSrc) begin
        if (bus.err_clr)        cntQ <= 8'd1;
        else if (cntQ != '1)    cntQ <= cntQ + 8'd1;
      end else if (bus.err_clr) begin
        cntQ <= '0;
      end
    end
  end

  assign bus.conflict_cnt = cntQ;
`else
  assign bus.conflict_cnt = '0;
`endif

  assign bus.Select          = selQ;
  assign bus.sel_valid       = validQ;
  assign bus.conflict        = conflictQ;
  assign bus.conflict_sticky = stickyQ;
  assign bus.conflict_src    = conflictSrcQ;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Directed bench for bus_select_encoder: two instances (HOLD_LAST=1 and 0) against
// an arithmetic reference model checked every falling edge, plus literal spot checks.
module tb_bus_select_encoder;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [31:0] src = 32'h0010_0000;
  logic        frz = 1'b0;
  logic        clr = 1'b0;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clock = ~clock;

  bus_select_encoder_if busA ();
  bus_select_encoder_if busB ();

  assign busA.src_out = src;
  assign busA.freeze  = frz;
  assign busA.err_clr = clr;
  assign busB.src_out = src;
  assign busB.freeze  = frz;
  assign busB.err_clr = clr;

  bus_select_encoder #(.HOLD_LAST(1'b1), .IDLE_SEL(5'd0)) dutA (
    .clock(clock), .clear_n(clear_n), .bus(busA.slave)
  );

  bus_select_encoder #(.HOLD_LAST(1'b0), .IDLE_SEL(5'd0)) dutB (
    .clock(clock), .clear_n(clear_n), .bus(busB.slave)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: index arithmetic on the raw strobe word.
  function automatic int lowestBit(input logic [31:0] v);
    longint iso;
    iso = longint'(v) & (-longint'(v));
    return $clog2(iso);
  endfunction

  function automatic int highestBit(input logic [31:0] v);
    return $clog2(longint'(v) + 1) - 1;
  endfunction

  int mSelA, mSelB, mValid, mConf, mSticky, mSrc, mCnt;

  always @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mSelA <= 0; mSelB <= 0; mValid <= 0; mConf <= 0;
      mSticky <= 0; mSrc <= 0; mCnt <= 0;
    end else if (!frz) begin
      int n;
      n = $countones(src);
      mValid <= (n > 0) ? 1 : 0;
      mConf  <= (n > 1) ? 1 : 0;
      if (n > 0) begin
        mSelA <= lowestBit(src);
        mSelB <= lowestBit(src);
      end else begin
        mSelB <= 0;
      end
      if (n > 1) begin
        mSticky <= 1;
        mSrc    <= highestBit(src);
        mCnt    <= clr ? 1 : ((mCnt + 1 > 255) ? 255 : mCnt + 1);
      end else if (clr) begin
        mSticky <= 0;
        mCnt    <= 0;
      end
    end
  end

  function automatic int cntExp(input int c);
`ifdef BUS_SELECT_CONFLICT_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  always @(negedge clock) begin
    chk("A.Select",   busA.Select,          mSelA);
    chk("A.valid",    busA.sel_valid,       mValid);
    chk("A.conflict", busA.conflict,        mConf);
    chk("A.sticky",   busA.conflict_sticky, mSticky);
    chk("A.src",      busA.conflict_src,    mSrc);
    chk("A.cnt",      busA.conflict_cnt,    cntExp(mCnt));
    chk("B.Select",   busB.Select,          mSelB);
    chk("B.valid",    busB.sel_valid,       mValid);
    chk("B.conflict", busB.conflict,        mConf);
    chk("B.sticky",   busB.conflict_sticky, mSticky);
  end

  task automatic step(input logic [31:0] s, input logic f, input logic c);
    src = s;
    frz = f;
    clr = c;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst.Select", busA.Select, 0);
    chk("rst.valid",  busA.sel_valid, 0);
    chk("rst.conf",   busA.conflict, 0);
    chk("rst.sticky", busA.conflict_sticky, 0);
    chk("rst.src",    busA.conflict_src, 0);
    chk("rst.cnt",    busA.conflict_cnt, 0);

    clear_n = 1'b1;
    step(32'h0010_0000, 1'b0, 1'b0);
    chk("rel.Select", busA.Select, 20);
    chk("rel.valid",  busA.sel_valid, 1);

    for (int i = 0; i < 32; i++) begin
      step(32'd1 << i, 1'b0, 1'b0);
      chk("sweep.Select", busA.Select, i);
      chk("sweep.conf",   busA.conflict, 0);
    end

    step(32'h0020_0008, 1'b0, 1'b0);
    chk("conf.Select", busA.Select, 3);
    chk("conf.pulse",  busA.conflict, 1);
    chk("conf.sticky", busA.conflict_sticky, 1);
    chk("conf.src",    busA.conflict_src, 21);
    chk("conf.cnt",    busA.conflict_cnt, cntExp(1));
    step(32'h0, 1'b0, 1'b0);
    chk("conf.drop",   busA.conflict, 0);

    step(32'd1 << 7, 1'b0, 1'b0);
    repeat (3) step(32'h0, 1'b0, 1'b0);
    chk("hold.A.Select", busA.Select, 7);
    chk("hold.A.valid",  busA.sel_valid, 0);
    chk("hold.B.Select", busB.Select, 0);

    step(32'h0000_0003, 1'b0, 1'b1);
    chk("clrdet.sticky", busA.conflict_sticky, 1);
    chk("clrdet.cnt",    busA.conflict_cnt, cntExp(1));
    chk("clrdet.src",    busA.conflict_src, 1);
    step(32'h0, 1'b0, 1'b1);
    chk("clr.sticky", busA.conflict_sticky, 0);
    chk("clr.cnt",    busA.conflict_cnt, 0);
    chk("clr.src",    busA.conflict_src, 1);

    repeat (300) step(32'h8000_0001, 1'b0, 1'b0);
    chk("sat.cnt",    busA.conflict_cnt, cntExp(255));
    chk("sat.src",    busA.conflict_src, 31);
    chk("sat.Select", busA.Select, 0);

    repeat (2) step(32'd1 << 12, 1'b1, 1'b1);
    chk("frz.Select", busA.Select, 0);
    chk("frz.valid",  busA.sel_valid, 1);
    chk("frz.conf",   busA.conflict, 1);
    chk("frz.sticky", busA.conflict_sticky, 1);
    chk("frz.cnt",    busA.conflict_cnt, cntExp(255));

    clear_n = 1'b0;
    #1;
    chk("arst.Select", busA.Select, 0);
    chk("arst.sticky", busA.conflict_sticky, 0);
    chk("arst.src",    busA.conflict_src, 0);
    chk("arst.valid",  busA.sel_valid, 0);
    clear_n = 1'b1;
    step(32'd1 << 5, 1'b0, 1'b0);
    chk("post.Select", busA.Select, 5);
    step(32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
